control_unit: RTL

Hardwired control sequencer that drives the `datapath` control inputs. It runs the fetch cycle, decodes the opcode in `ir[31:27]`, and steps through one control step per clock for each supported instruction. It sits directly upstream of `datapath`. It receives `ir` from the datapath and drives every load, drive, select, memory and ALU strobe that the datapath consumes.

---
 rtl/control_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the datapath. Runs fetch
// (T0-T2), decodes ir[31:27], then issues one control step per clock until
// the instruction completes and fetch restarts. Halt parks in HALT until reset.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic        write,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_low_out,
    output logic        z_high_out,
    output logic        c_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        inport_out,
    output logic        outport_in,
    output logic [3:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    // Instruction classes sharing one control-step sequence
    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_LD   = 4'd1;
    localparam logic [3:0] C_LDI  = 4'd2;
    localparam logic [3:0] C_ST   = 4'd3;
    localparam logic [3:0] C_R    = 4'd4;
    localparam logic [3:0] C_I    = 4'd5;
    localparam logic [3:0] C_MD   = 4'd6;
    localparam logic [3:0] C_NN   = 4'd7;
    localparam logic [3:0] C_IN   = 4'd8;
    localparam logic [3:0] C_OUT  = 4'd9;
    localparam logic [3:0] C_HALT = 4'd10;

    localparam logic [3:0] ALU_ADD = 4'h2;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] cls;
    logic [3:0] op_alu;
    logic [4:0] opcode;

    assign opcode = ir[31:27];

    // Classify the opcode and pick the ALU operation it uses in execute
    always_comb begin
        cls    = C_NOP;
        op_alu = 4'h0;
        case (opcode)
            5'd0:  cls = C_LD;
            5'd1:  cls = C_LDI;
            5'd2:  cls = C_ST;
            5'd3:  begin cls = C_R;  op_alu = 4'h2; end
            5'd4:  begin cls = C_R;  op_alu = 4'h3; end
            5'd5:  begin cls = C_R;  op_alu = 4'h0; end
            5'd6:  begin cls = C_R;  op_alu = 4'h1; end
            5'd7:  begin cls = C_R;  op_alu = 4'h4; end
            5'd8:  begin cls = C_R;  op_alu = 4'h5; end
            5'd9:  begin cls = C_R;  op_alu = 4'h6; end
            5'd10: begin cls = C_R;  op_alu = 4'h7; end
            5'd11: begin cls = C_I;  op_alu = 4'h2; end
            5'd12: begin cls = C_I;  op_alu = 4'h0; end
            5'd13: begin cls = C_I;  op_alu = 4'h1; end
            5'd14: begin cls = C_MD; op_alu = 4'h8; end
            5'd15: begin cls = C_MD; op_alu = 4'h9; end
            5'd16: begin cls = C_NN; op_alu = 4'hA; end
            5'd17: begin cls = C_NN; op_alu = 4'hB; end
            5'd22: cls = C_IN;
            5'd23: cls = C_OUT;
            5'd25: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

    // Next-state: each instruction class leaves to T0 after its last step
    always_comb begin
        state_nxt = S_T0;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = (cls == C_NOP)  ? S_T0 :
                                (cls == C_HALT) ? S_HALT : S_T3;
            S_T3:   state_nxt = (cls == C_IN || cls == C_OUT) ? S_T0 : S_T4;
            S_T4:   state_nxt = (cls == C_NN) ? S_T0 : S_T5;
            S_T5:   state_nxt = (cls == C_LD || cls == C_ST || cls == C_MD) ? S_T6 : S_T0;
            S_T6:   state_nxt = (cls == C_MD) ? S_T0 : S_T7;
            S_T7:   state_nxt = S_T0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_nxt;
    end

    // Moore output decode of state plus opcode class
    always_comb begin
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
        mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; write = 1'b0;
        ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0;
        z_high_out = 1'b0; c_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
        ba_out = 1'b0; inport_out = 1'b0; outport_in = 1'b0;
        alu_op = 4'h0;
        run = (state >= S_T0) && (state <= S_T7);
        case (state)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
            S_T1: begin z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: case (cls)
                C_LD, C_LDI, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                C_R, C_I:          begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                C_MD:              begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                C_NN:              begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_alu; end
                C_IN:              begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                C_OUT:             begin gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                C_LD, C_LDI, C_ST: begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
                C_R:               begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_alu; end
                C_I:               begin c_out = 1'b1; z_in = 1'b1; alu_op = op_alu; end
                C_MD:              begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_alu; end
                C_NN:              begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                C_LD, C_ST:        begin z_low_out = 1'b1; mar_in = 1'b1; end
                C_LDI, C_R, C_I:   begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                C_MD:              begin z_low_out = 1'b1; lo_in = 1'b1; end
                default: ;
            endcase
            S_T6: case (cls)
                C_LD:              begin read = 1'b1; mdr_in = 1'b1; end
                C_ST:              begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                C_MD:              begin z_high_out = 1'b1; hi_in = 1'b1; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD:              begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                C_ST:              write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule
